// File: rtl/mul_div_pkg.sv
// Shared RISC-V M-extension op encodings and the sequencer state encoding.
package mul_div_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_div_seq.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the final edge.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating, cnt counts down from XLEN-1 to 0
// DONE  | result held until out_ready
module mul_div_seq
   import mul_div_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int CNT_W = $clog2(XLEN);

   state_e              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op_q;
   logic                a_neg_q, b_neg_q;
   logic [XLEN-1:0]     b_mag;
   logic [2*XLEN-1:0]   acc;

   logic                accept, a_signed, b_signed, a_neg, b_neg;
   logic                div_zero, div_ovf, bypass;
   logic [XLEN-1:0]     a_abs, b_abs, bypass_res;
   logic [XLEN:0]       lhs, alu;
   logic                q_bit;
   logic [2*XLEN-1:0]   acc_step, prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, calc_res;

   assign accept = (state == ST_IDLE) && in_valid && !flush;

   always_comb begin
      a_signed   = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                   (in_op == OP_DIV)  || (in_op == OP_REM);
      b_signed   = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
      a_neg      = a_signed && in_a[XLEN-1];
      b_neg      = b_signed && in_b[XLEN-1];
      a_abs      = a_neg ? -in_a : in_a;
      b_abs      = b_neg ? -in_b : in_b;
      div_zero   = in_op[2] && (in_b == '0);
      div_ovf    = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      bypass     = div_zero || div_ovf;
      bypass_res = '0;
      if (div_zero)
         bypass_res = in_op[1] ? in_a : '1;
      else if (div_ovf)
         bypass_res = in_op[1] ? '0 : in_a;
   end

   // One shared adder: subtract-and-test for divide, conditional add for multiply.
   always_comb begin
      if (op_q[2]) begin
         lhs      = acc[2*XLEN-1:XLEN-1];
         alu      = lhs - {1'b0, b_mag};
         q_bit    = ~alu[XLEN];
         acc_step = {(q_bit ? alu[XLEN-1:0] : lhs[XLEN-1:0]), acc[XLEN-2:0], q_bit};
      end else begin
         lhs      = {1'b0, acc[2*XLEN-1:XLEN]};
         alu      = lhs + (acc[0] ? {1'b0, b_mag} : '0);
         q_bit    = 1'b0;
         acc_step = {alu, acc[XLEN-1:1]};
      end
   end

   always_comb begin
      prod_fix = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
      quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_fix  = a_neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              calc_res = quo_fix;
         default:                      calc_res = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid)
               state_nxt = bypass ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (cnt == '0)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush)
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         op_q    <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         b_mag   <= '0;
         acc     <= '0;
         out_res <= '0;
         out_tag <= '0;
      end else if (accept) begin
         cnt     <= CNT_W'(XLEN-1);
         op_q    <= in_op;
         a_neg_q <= a_neg;
         b_neg_q <= b_neg;
         b_mag   <= b_abs;
         acc     <= {{XLEN{1'b0}}, a_abs};
         out_tag <= in_tag;
         if (bypass)
            out_res <= bypass_res;
      end else if (state == ST_CALC && !flush) begin
         acc <= acc_step;
         cnt <= cnt - CNT_W'(1);
         if (cnt == '0)
            out_res <= calc_res;
      end
   end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mul_div_seq;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [2:0]       in_op;
   logic [XLEN-1:0]  in_a, in_b, out_res;
   logic [TAG_W-1:0] in_tag, out_tag;

   int n_checks = 0;
   int n_pass   = 0;

   mul_div_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'(a);
      ub  = longint'(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (op)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Called at posedge+#1; leaves the bench at posedge+#1 with the unit back in IDLE.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input int hold, input bit poke);
      int          edges;
      logic [31:0] exp;
      exp = ref_res(op, a, b);
      check("idle_ready", in_ready, 1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tg;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      if (poke) begin
         in_valid = 1'b1; in_op = ~op; in_a = $urandom; in_b = $urandom; in_tag = ~tg;
      end
      while (!out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      in_valid = 1'b0;
      check("latency", edges, ref_lat(op, a, b));
      check("result", out_res, exp);
      check("tag", out_tag, tg);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_res", out_res, exp);
         check("hold_tag", out_tag, tg);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("after_hs_valid", out_valid, 0);
      check("after_hs_ready", in_ready, 1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_res", out_res, 0);
      check("rst_tag", out_tag, 0);
      rst = 1'b0;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 1'b0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 1'b0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1'b1);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 1'b0);
      do_op(3'd4, 32'd7, 32'd0, 5'd5, 0, 1'b0);
      do_op(3'd6, 32'd7, 32'd0, 5'd6, 0, 1'b0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 1'b0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 1'b0);
      do_op(3'd4, -32'sd7, 32'd2, 5'd9, 0, 1'b0);
      do_op(3'd6, -32'sd7, 32'd2, 5'd10, 0, 1'b0);
      do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd11, 5, 1'b1);

      // flush at CALC cycle 10
      in_valid = 1'b1; in_op = 3'd0; in_a = 32'd100; in_b = 32'd200; in_tag = 5'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("flush_busy_before", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", in_ready, 1);
      check("flush_valid", out_valid, 0);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("flush_no_pulse", seen, 0);
      do_op(3'd0, 32'd3, 32'd4, 5'd13, 0, 1'b0);

      // flush discards a result sitting in DONE
      in_valid = 1'b1; in_op = 3'd5; in_a = 32'd9; in_b = 32'd0; in_tag = 5'd14;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("done_before_flush", out_valid, 1);
      flush = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_done_valid", out_valid, 0);
      check("flush_done_ready", in_ready, 1);

      // flush beats in_valid in IDLE
      in_valid = 1'b1; flush = 1'b1; in_op = 3'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_prio_busy", busy, 0);

      // reset mid-CALC
      in_valid = 1'b1; in_op = 3'd1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_tag = 5'd15;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", in_ready, 1);
      check("rst_mid_res", out_res, 0);
      check("rst_mid_tag", out_tag, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(3'd7, 32'd100, 32'd7, 5'd16, 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
               5'($urandom), $urandom_range(0, 2), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; must be even and at least 8.
REQ-002 Parameter TAG_W, default 5: width of the destination-register tag carried with each operation.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: operation request.
REQ-006 in_ready  output  1: unit can accept a request.
REQ-007 in_op  input  3: operation select (RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-008 in_a, in_b  input  XLEN: rs1 and rs2 operand values.
REQ-009 in_tag  input  TAG_W: destination tag.
REQ-010 flush  input  1: kill the in-flight operation (exception or redirect).
REQ-011 out_valid  output  1: result available.
REQ-012 out_ready  input  1: consumer accepts the result.
REQ-013 out_res  output  XLEN: result value.
REQ-014 out_tag  output  TAG_W: tag of the result.
REQ-015 busy  output  1: high in any state other than IDLE.

Function
REQ-016 The FSM shall have three states: IDLE, CALC, DONE.
REQ-017 in_ready shall be 1 only in IDLE.
REQ-018 A request is accepted on a rising edge with in_valid & in_ready & !flush; at that edge the unit latches the op, the operand magnitudes and sign flags, and the tag.
REQ-019 A normal accept moves IDLE->CALC with iteration counter = XLEN-1.
REQ-020 Multiply shall use radix-2 shift-add on magnitudes with a 2*XLEN product; operand signedness follows the op: MULHSU treats rs1 as signed and rs2 as unsigned.
REQ-021 Divide/remainder shall use restoring division on magnitudes, one quotient bit per cycle.
REQ-022 CALC shall last exactly XLEN cycles; the edge ending the last cycle (counter == 0) performs sign correction and selects the result into the output register, then moves to DONE.
REQ-023 out_valid shall therefore rise XLEN+1 edges after the accepting edge.
REQ-024 Result select: MUL gives the low XLEN product bits; MULH, MULHSU and MULHU give the high XLEN bits.
REQ-025 Signed quotient and remainder signs: quotient negative iff signs differ; remainder takes the dividend's sign.
REQ-026 Divide by zero (in_b == 0, ops 4-7) shall bypass CALC, going IDLE->DONE at the accepting edge: quotient all-ones, remainder = in_a.
REQ-027 Signed overflow (DIV/REM with in_a = -2^(XLEN-1) and in_b = -1) shall bypass CALC, going IDLE->DONE: DIV result = in_a, REM result = 0.
REQ-028 out_valid shall be 1 exactly in DONE.
REQ-029 In DONE, out_res and out_tag shall be held stable until the handshake edge.
REQ-030 DONE & out_ready shall go to IDLE at the next edge; there is no same-cycle re-accept, so back-to-back throughput is one op per XLEN+2 cycles.
REQ-031 flush, in any state, shall force IDLE at the next edge and discard any result, with out_valid low from that edge.
REQ-032 flush has priority over both in_valid and out_ready.
REQ-033 in_valid asserted while not in IDLE shall be ignored with no state change.

Reset
REQ-034 While rst is high, state = IDLE.
REQ-035 Reset values: out_valid 0, busy 0, in_ready 1, out_res 0, out_tag 0; counter and datapath registers 0.
REQ-036 Reset asserted mid-CALC or in DONE shall drop the result with no output pulse.
REQ-037 The first accept is permitted on the first edge after rst deasserts.

Structure
REQ-038 Package mul_div_pkg shall hold the op-encoding localparams and the FSM state encoding; the execute stage imports the same op encodings.
REQ-039 Single module; no sub-module (the shared shift/add-subtract datapath is too small to split).
REQ-040 The iteration counter shall be $clog2(XLEN) bits wide.

Verification (XLEN=32)
REQ-041 MUL 7 x 0xFFFFFFFD -> out_res 0xFFFFFFEB; out_valid rises 33 edges after the accept.
REQ-042 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-043 DIV 7 / 0 -> 0xFFFFFFFF and REM 7 / 0 -> 7, each valid 1 edge after the accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-044 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-045 flush at CALC cycle 10 -> in_ready 1 next cycle, no out_valid; a new MUL 3x4 -> 12 with the correct tag.
REQ-046 Hold out_ready = 0 for 5 cycles in DONE -> out_res and out_tag stable, in_ready 0; release -> IDLE after 1 edge. Also assert rst mid-CALC -> all outputs at reset values immediately.
